sd_child_scheduler: RTL
=======================

Name: sd_child_scheduler

Overview:
- Round-robin scheduler that shares one resource among the N_CHILD leaf instances of a generated sub-hierarchy level.
- Sits in the parent level beside its inst_0..inst_(N-1) children and grants exclusive access one child at a time.
- Enforces a bounded hold time, revokes overlong owners, and reports the timeout.

Parameters:
N_CHILD, 5, number of requesters (children); legal range 2..16
MAX_HOLD, 16, maximum consecutive GRANT cycles before forced revoke; legal range 1..255
ID_W, $clog2(N_CHILD), width of the grant/timeout id fields

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
en  input  1  1 = new grants allowed; 0 = no new grants, current grant runs to completion
req  input  N_CHILD  level request per child; held high while using the resource, dropped to release
grant  output  N_CHILD  one-hot grant, registered
grant_valid  output  1  |grant
grant_id  output  ID_W  index of owner; 0 when grant_valid=0
busy  output  1  state != IDLE
timeout_pulse  output  1  one-cycle pulse on forced revoke
timeout_id  output  ID_W  index revoked; valid while timeout_pulse=1, else holds last value

Behaviour:
- Reset: grant=0, grant_valid=0, grant_id=0, busy=0, timeout_pulse=0, timeout_id=0, state=IDLE, rr pointer=0, hold counter=0, mask=0.
- States: IDLE, GRANT, GAP.
- IDLE:
  - If en=1 and any (req & ~mask), pick the first eligible index scanning from the pointer upward with wrap.
  - Next edge: grant[i]=1, state=GRANT, hold counter=1, pointer=(i+1) mod N_CHILD.
  - Latency: req sampled at edge t gives grant visible after edge t+1.
- GRANT, release: if req[owner]=0, next edge grant=0 and state=GAP.
- GRANT, timeout: else if hold counter==MAX_HOLD, next edge grant=0, timeout_pulse=1, timeout_id=owner, mask[owner]=1, state=GAP.
- GRANT, otherwise: hold counter increments. It saturates at MAX_HOLD and never wraps.
- GAP: exactly one idle cycle (turnaround), then IDLE. No grant is issued in GAP.
- Minimum spacing between grants is 2 cycles with grant low.
- Mask: mask[i] clears on any cycle where req[i]=0. A timed-out child must drop req for at least 1 cycle before it is eligible again.
- en=0 affects only the IDLE->GRANT transition. An active grant is unaffected by en.
- Simultaneous release and timeout (req drop on the cycle counter==MAX_HOLD): treated as a release. No timeout_pulse, no mask.
- Requests from non-owners during GRANT/GAP are ignored, with no queuing. Arbitration happens only in IDLE, on current req.
- Pointer wrap: after granting N_CHILD-1, the pointer becomes 0.
- Fairness: with all children requesting continuously and releasing normally, the grant order is 0,1,2,...,N-1,0,...
- Reset mid-GRANT: grant=0 on the reset edge. The pointer, mask and counter return to reset values.
- grant is always one-hot or zero. Assertion: $onehot0(grant).

Decomposition:
- Package sd_sched_pkg:
  - state enum typedef {IDLE, GRANT, GAP}.
  - Default constants SD_N_CHILD=5 and SD_MAX_HOLD=16.
- Sub-module sd_rr_pick: combinational rotate-priority picker.
  - Inputs: eligible vector, pointer.
  - Outputs: found, index.
  - Instantiated once.
- The FSM, counter, mask and pointer registers live in the top module.

Test Plan:
- Reset, then req=5'b00100, en=1 -> grant=5'b00100 two edges after req is applied at the sampled edge; grant_id=2; pointer=3. Drop req -> grant=0 next edge, busy high one more cycle (GAP).
- req=5'b11111 held, each owner releases after 3 cycles -> grant ids in order 0,1,2,3,4,0. Each grant lasts 3 cycles, with 2 idle cycles between grants.
- MAX_HOLD=16, req=5'b00010 never dropped -> grant held 16 cycles, then timeout_pulse=1 for one cycle with timeout_id=1. Child 1 is not regranted while req stays high; after req low 1 cycle and then high, it is granted again.
- en=0 with req=5'b10001 -> no grant, busy=0. Raise en -> grant id 0. Drop en during GRANT -> grant persists until release.
- Release on the same cycle counter reaches MAX_HOLD -> no timeout_pulse, child not masked, normal GAP.
- Assert rst while grant=5'b01000 -> all outputs 0 after the edge. With req=5'b11111 afterwards, the first grant is id 0 (pointer reset).

Source files
------------

// File: rtl/sd_sched_pkg.sv
// Shared types and default sizing for the child-level round-robin scheduler.
package sd_sched_pkg;

  localparam int SD_N_CHILD  = 5;
  localparam int SD_MAX_HOLD = 16;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } state_t;

endpackage

// File: rtl/sd_rr_pick.sv
// Rotate-priority picker: first set bit of eligible, scanning upward from ptr with wrap.
module sd_rr_pick #(
  parameter int N_CHILD = 5,
  parameter int ID_W    = $clog2(N_CHILD)
) (
  input  logic [N_CHILD-1:0] eligible,
  input  logic [ID_W-1:0]    ptr,
  output logic               found,
  output logic [ID_W-1:0]    index
);

  int cand;

  // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    found = 1'b0;
    index = '0;
    cand  = 0;
    // Scan from the farthest offset down so the nearest eligible child wins.
    for (int off = N_CHILD - 1; off >= 0; off--) begin
      cand = int'(ptr) + off;
      if (cand >= N_CHILD) cand = cand - N_CHILD;
      if (eligible[cand]) begin
        found = 1'b1;
        index = ID_W'(cand);
      end
    end
  end

endmodule

// File: rtl/sd_child_scheduler.sv
// Round-robin owner of a shared resource among N_CHILD sibling instances, with a
// bounded hold time, forced revoke of overlong owners and a one-cycle timeout report.
module sd_child_scheduler
  import sd_sched_pkg::*;
#(
  parameter int N_CHILD  = SD_N_CHILD,
  parameter int MAX_HOLD = SD_MAX_HOLD,
  parameter int ID_W     = $clog2(N_CHILD)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [N_CHILD-1:0] req,
  output logic [N_CHILD-1:0] grant,
  output logic               grant_valid,
  output logic [ID_W-1:0]    grant_id,
  output logic               busy,
  output logic               timeout_pulse,
  output logic [ID_W-1:0]    timeout_id
);

  localparam logic [7:0]         HOLD_MAX = 8'(MAX_HOLD);
  localparam logic [N_CHILD-1:0] ONE_HOT0 = N_CHILD'(1);
  localparam logic [ID_W-1:0]    LAST_ID  = ID_W'(N_CHILD - 1);

  state_t             state;
  logic [ID_W-1:0]    ptr;
  logic [7:0]         hold_cnt;
  logic [N_CHILD-1:0] mask;
  logic               pick_found;
  logic [ID_W-1:0]    pick_idx;

  sd_rr_pick #(
    .N_CHILD (N_CHILD),
    .ID_W    (ID_W)
  ) u_pick (
    .eligible (req & ~mask),
    .ptr      (ptr),
    .found    (pick_found),
    .index    (pick_idx)
  );

  assign grant_valid = |grant;
  assign busy        = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      ptr           <= '0;
      hold_cnt      <= '0;
      mask          <= '0;
      grant         <= '0;
      grant_id      <= '0;
      timeout_pulse <= 1'b0;
      timeout_id    <= '0;
    end else begin
      timeout_pulse <= 1'b0;
      // A revoked child becomes eligible again only after dropping its request.
      mask          <= mask & req;
      case (state)
        IDLE: begin
          if (en && pick_found) begin
            grant    <= ONE_HOT0 << pick_idx;
            grant_id <= pick_idx;
            hold_cnt <= 8'd1;
            ptr      <= (pick_idx == LAST_ID) ? '0 : pick_idx + 1'b1;
            state    <= GRANT;
          end
        end
        GRANT: begin
          // Release takes priority over a timeout landing on the same cycle.
          if (!req[grant_id]) begin
            grant    <= '0;
            grant_id <= '0;
            state    <= GAP;
          end else if (hold_cnt == HOLD_MAX) begin
            grant         <= '0;
            grant_id      <= '0;
            timeout_pulse <= 1'b1;
            timeout_id    <= grant_id;
            mask          <= (mask & req) | grant;
            state         <= GAP;
          end else if (hold_cnt < HOLD_MAX) begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  a_grant_onehot0: assert property (@(posedge clk) $onehot0(grant));

endmodule
